// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage core: forwarding, stall/flush control,
// multicycle execute sequencing, perf counters and a stall watchdog.
module hazard_unit #(
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           RA1D,
    input  logic [3:0]           RA2D,
    input  logic [3:0]           RA1E,
    input  logic [3:0]           RA2E,
    input  logic [3:0]           WA3E,
    input  logic [3:0]           WA3M,
    input  logic [3:0]           WA3W,
    input  logic                 MemtoRegE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 PCWrPendingF,
    input  logic                 PCSrcW,
    input  logic                 BranchTakenE,
    input  logic                 MultiStartE,
    input  logic                 MultiDoneE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushM,
    output logic                 Busy,
    output logic [CNT_WIDTH-1:0] StallCount,
    output logic [CNT_WIDTH-1:0] FlushCount,
    output logic                 HazardTimeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } multiState_t;

    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

    multiState_t state;
    multiState_t stateNext;

    logic        ldrStall;
    logic        anyFlush;
    logic        matchA1M;
    logic        matchA1W;
    logic        matchA2M;
    logic        matchA2W;
    logic [15:0] runCount;

    assign matchA1M = RegWriteM && (RA1E == WA3M);
    assign matchA1W = RegWriteW && (RA1E == WA3W);
    assign matchA2M = RegWriteM && (RA2E == WA3M);
    assign matchA2W = RegWriteW && (RA2E == WA3W);

    // Memory stage result is younger, so it wins over writeback.
    always_comb begin
        ForwardAE = 2'b00;
        priority case (1'b1)
            matchA1M: ForwardAE = 2'b10;
            matchA1W: ForwardAE = 2'b01;
            default:  ForwardAE = 2'b00;
        endcase
    end

    always_comb begin
        ForwardBE = 2'b00;
        priority case (1'b1)
            matchA2M: ForwardBE = 2'b10;
            matchA2W: ForwardBE = 2'b01;
            default:  ForwardBE = 2'b00;
        endcase
    end

    assign ldrStall = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A start with a coincident done is a single-cycle op: never busy.
    always_comb begin
        stateNext = state;
        Busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (MultiStartE && !MultiDoneE) begin
                    stateNext = BUSY;
                    Busy      = 1'b1;
                end
            end
            BUSY: begin
                if (MultiDoneE) begin
                    stateNext = IDLE;
                end else begin
                    Busy = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (Busy) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else begin
            StallD = ldrStall;
            StallF = ldrStall || PCWrPendingF;
            FlushD = PCWrPendingF || PCSrcW || BranchTakenE;
            FlushE = ldrStall || BranchTakenE;
        end
    end

    assign anyFlush = FlushD || FlushE || FlushM;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            StallCount <= StallCount + {{(CNT_WIDTH-1){1'b0}}, StallF};
            FlushCount <= FlushCount + {{(CNT_WIDTH-1){1'b0}}, anyFlush};
        end
    end

    // Flag latches one edge after the run counter sits at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            runCount      <= '0;
            HazardTimeout <= 1'b0;
        end else begin
            if (!StallF) begin
                runCount <= '0;
            end else if (runCount != TimeoutVal) begin
                runCount <= runCount + 16'd1;
            end
            if (runCount == TimeoutVal) begin
                HazardTimeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomised plus directed scoreboard bench for hazard_unit.
// Expected responses are queued by the driver and checked by a monitor.
module tb_hazard_unit;

    localparam int CW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic          MemtoRegE, RegWriteM, RegWriteW;
    logic          PCWrPendingF, PCSrcW, BranchTakenE;
    logic          MultiStartE, MultiDoneE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE;
    logic          FlushD, FlushE, FlushM;
    logic          Busy, HazardTimeout;
    logic [CW-1:0] StallCount, FlushCount;

    hazard_unit #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .RA1D(RA1D),
        .RA2D(RA2D),
        .RA1E(RA1E),
        .RA2E(RA2E),
        .WA3E(WA3E),
        .WA3M(WA3M),
        .WA3W(WA3W),
        .MemtoRegE(MemtoRegE),
        .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW),
        .PCWrPendingF(PCWrPendingF),
        .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE),
        .MultiStartE(MultiStartE),
        .MultiDoneE(MultiDoneE),
        .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE),
        .StallF(StallF),
        .StallD(StallD),
        .StallE(StallE),
        .FlushD(FlushD),
        .FlushE(FlushE),
        .FlushM(FlushM),
        .Busy(Busy),
        .StallCount(StallCount),
        .FlushCount(FlushCount),
        .HazardTimeout(HazardTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sF, sD, sE, fD, fE, fM, busy, to;
        logic [7:0] sc;
        logic [7:0] fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: op in flight, running totals, current stall run.
    bit   mOp;
    int   mSc, mFc, mRun;
    bit   mTo;

    function automatic logic [1:0] fwd(input logic [3:0] ra);
        if (RegWriteM && ra == WA3M) return 2'd2;
        if (RegWriteW && ra == WA3W) return 2'd1;
        return 2'd0;
    endfunction

    task automatic push();
        exp_t e;
        bit   ldr;
        if (!reset) begin
            mOp  = 0;
            mSc  = 0;
            mFc  = 0;
            mRun = 0;
            mTo  = 0;
        end
        ldr    = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
        e.busy = mOp ? !MultiDoneE : (MultiStartE && !MultiDoneE);
        e.fa   = fwd(RA1E);
        e.fb   = fwd(RA2E);
        if (e.busy) begin
            {e.sF, e.sD, e.sE, e.fM} = 4'b1111;
            {e.fD, e.fE} = 2'b00;
        end else begin
            e.sE = 0;
            e.fM = 0;
            e.sD = ldr;
            e.sF = ldr || PCWrPendingF;
            e.fD = PCWrPendingF || PCSrcW || BranchTakenE;
            e.fE = ldr || BranchTakenE;
        end
        e.sc = 8'(mSc);
        e.fc = 8'(mFc);
        e.to = mTo;
        q.push_back(e);
        if (reset) begin
            mSc += int'(e.sF);
            mFc += int'(e.fD || e.fE || e.fM);
            if (mRun == TO) mTo = 1;
            mRun = e.sF ? ((mRun < TO) ? mRun + 1 : TO) : 0;
            mOp  = e.busy;
        end
    endtask

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", n, got, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ForwardAE", 32'(ForwardAE), 32'(e.fa));
                chk("ForwardBE", 32'(ForwardBE), 32'(e.fb));
                chk("StallF", 32'(StallF), 32'(e.sF));
                chk("StallD", 32'(StallD), 32'(e.sD));
                chk("StallE", 32'(StallE), 32'(e.sE));
                chk("FlushD", 32'(FlushD), 32'(e.fD));
                chk("FlushE", 32'(FlushE), 32'(e.fE));
                chk("FlushM", 32'(FlushM), 32'(e.fM));
                chk("Busy", 32'(Busy), 32'(e.busy));
                chk("StallCount", 32'(StallCount), 32'(e.sc));
                chk("FlushCount", 32'(FlushCount), 32'(e.fc));
                chk("HazardTimeout", 32'(HazardTimeout), 32'(e.to));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleIn();
        {RA1D, RA2D, RA1E, RA2E} = {4'd1, 4'd2, 4'd6, 4'd7};
        {WA3E, WA3M, WA3W} = {4'd9, 4'd10, 4'd11};
        {MemtoRegE, RegWriteM, RegWriteW} = 3'b000;
        {PCWrPendingF, PCSrcW, BranchTakenE} = 3'b000;
        {MultiStartE, MultiDoneE} = 2'b00;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            push();
        end
    endtask

    function automatic logic [3:0] rreg();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 3));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        idleIn();
        reset = 0;
        cyc(2);
        tick(); reset = 1; push();
        // forwarding priority on both operands
        tick(); RA1E = 3; WA3M = 3; WA3W = 3;
        RegWriteM = 1; RegWriteW = 1; push();
        tick(); RegWriteM = 0; push();
        tick(); RegWriteW = 0; push();
        tick(); RA1E = 6; RA2E = 3; RegWriteM = 1; RegWriteW = 1; push();
        tick(); RegWriteM = 0; push();
        tick(); RegWriteW = 0; push();
        // load-use
        tick(); idleIn(); MemtoRegE = 1; WA3E = 5; RA2D = 5; push();
        tick(); MemtoRegE = 0; push();
        // branch and pending PC write
        tick(); idleIn(); BranchTakenE = 1; push();
        tick(); BranchTakenE = 0; PCWrPendingF = 1; push();
        tick(); PCWrPendingF = 0; PCSrcW = 1; push();
        tick(); PCSrcW = 0; push();
        // multicycle op, start at 0 and done at 4
        tick(); MultiStartE = 1; push();
        tick(); MultiStartE = 0; push();
        cyc(2);
        tick(); MultiDoneE = 1; push();
        tick(); MultiDoneE = 0; push();
        // single-cycle op
        tick(); MultiStartE = 1; MultiDoneE = 1; push();
        tick(); MultiStartE = 0; MultiDoneE = 0; push();
        // reset in the middle of an op, then a stray done
        tick(); MultiStartE = 1; push();
        tick(); MultiStartE = 0; push();
        tick(); reset = 0; push();
        tick(); reset = 1; push();
        tick(); MultiDoneE = 1; push();
        tick(); MultiDoneE = 0; push();
        // watchdog: a 3-cycle run stays clear, a 5-cycle run trips it
        tick(); reset = 0; push();
        tick(); reset = 1; PCWrPendingF = 1; push();
        cyc(2);
        tick(); PCWrPendingF = 0; push();
        cyc(3);
        tick(); PCWrPendingF = 1; push();
        cyc(4);
        tick(); PCWrPendingF = 0; push();
        cyc(3);
        // random traffic with occasional resets
        for (int i = 0; i < 700; i++) begin
            tick();
            reset = ($urandom_range(0, 79) != 0);
            RA1D = rreg(); RA2D = rreg();
            RA1E = rreg(); RA2E = rreg();
            WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
            MemtoRegE = ($urandom_range(0, 3) == 0);
            RegWriteM = $urandom_range(0, 1) == 1;
            RegWriteW = $urandom_range(0, 1) == 1;
            PCWrPendingF = ($urandom_range(0, 4) == 0);
            PCSrcW = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 7) == 0);
            MultiStartE = ($urandom_range(0, 9) == 0);
            MultiDoneE = ($urandom_range(0, 4) == 0);
            push();
        end
        tick();
        idleIn();
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
